// File: rtl/counter_ctrl.sv
// Control front-end for the up/down counter pair: debounces the run and swap buttons
// and sequences STOP/RUN/SWAP into registered enable/swap/running outputs.
module counter_ctrl #(
   parameter int DB_CYCLES = 4,
   parameter int AUTO_SWAP = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic btn_run,
   input  logic btn_swap,
   output logic enable,
   output logic swap,
   output logic running
);

   localparam int DB_W = $clog2(DB_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam int AS_W = (AUTO_SWAP < 2) ? 1 : $clog2(AUTO_SWAP);
   localparam logic [AS_W-1:0] AUTO_LAST = (AUTO_SWAP > 0) ? AS_W'(AUTO_SWAP - 1) : '0;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      SWAP = 2'd2
   } ctrlState_t;

   // bit 0 carries the run button, bit 1 the swap button
   logic [1:0]      btnRaw;
   logic [1:0]      syncA;
   logic [1:0]      syncB;
   logic [1:0]      debounced;
   logic [1:0]      debPrev;
   logic [1:0]      pressEv;
   logic [DB_W-1:0] dbCount [2];
   logic            runEv;
   logic            swapEv;

   ctrlState_t      state;
   ctrlState_t      nextState;
   ctrlState_t      retState;
   ctrlState_t      nextRet;
   logic [AS_W-1:0] autoCount;
   logic            autoFire;
   logic            nextEnable;
   logic            nextSwap;
   logic            nextRunning;

   assign btnRaw = {btn_swap, btn_run};

   // Synchronize each button, then only accept a new level once it has held for
   // DB_CYCLES consecutive cycles; the flip happens on the cycle the count would reach it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         syncA     <= '0;
         syncB     <= '0;
         debounced <= '0;
         debPrev   <= '0;
         for (int i = 0; i < 2; i++) begin
            dbCount[i] <= '0;
         end
      end else begin
         syncA   <= btnRaw;
         syncB   <= syncA;
         debPrev <= debounced;
         for (int i = 0; i < 2; i++) begin
            if (syncB[i] == debounced[i]) begin
               dbCount[i] <= '0;
            end else if (dbCount[i] == DB_LAST) begin
               dbCount[i]   <= '0;
               debounced[i] <= syncB[i];
            end else begin
               dbCount[i] <= dbCount[i] + DB_W'(1);
            end
         end
      end
   end

   // A press is a rising debounced level; releases are deliberately silent.
   assign pressEv = debounced & ~debPrev;
   assign runEv   = pressEv[0];
   assign swapEv  = pressEv[1];

   assign autoFire = (AUTO_SWAP > 0) && (state == RUN) && (autoCount == AUTO_LAST);

   // Next-state logic. A run press arriving with a swap press selects the toggled
   // state as the return target, so the swap cycle always happens first.
   always_comb begin
      nextState = state;
      nextRet   = retState;
      case (state)
         STOP: begin
            if (swapEv) begin
               nextState = SWAP;
               nextRet   = runEv ? RUN : STOP;
            end else if (runEv) begin
               nextState = RUN;
            end
         end
         RUN: begin
            if (swapEv) begin
               nextState = SWAP;
               nextRet   = runEv ? STOP : RUN;
            end else if (runEv) begin
               nextState = STOP;
            end else if (autoFire) begin
               nextState = SWAP;
               nextRet   = RUN;
            end
         end
         SWAP: begin
            nextState = retState;
         end
         default: begin
            nextState = STOP;
            nextRet   = STOP;
         end
      endcase
   end

   // Outputs are decoded from the next state so they land in the same edge as the state.
   always_comb begin
      nextEnable  = (nextState != STOP);
      nextSwap    = (nextState == SWAP);
      nextRunning = (nextState == RUN) || ((nextState == SWAP) && (nextRet == RUN));
   end

   // State register, auto-swap period counter and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= STOP;
         retState  <= STOP;
         autoCount <= '0;
         enable    <= 1'b0;
         swap      <= 1'b0;
         running   <= 1'b0;
      end else begin
         state    <= nextState;
         retState <= nextRet;
         if ((AUTO_SWAP > 0) && (state == RUN) && (nextState == RUN)) begin
            autoCount <= autoCount + AS_W'(1);
         end else begin
            autoCount <= '0;
         end
         enable  <= nextEnable;
         swap    <= nextSwap;
         running <= nextRunning;
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: per-cycle expected outputs are queued as
// stimulus is driven and popped after each clock edge.
module tb_counter_ctrl;

   logic clock;
   logic reset_n;
   logic btn_run;
   logic btn_swap;
   logic enable;
   logic swap;
   logic running;
   logic autoRun;
   logic autoSwapBtn;
   logic autoEnable;
   logic autoSwapOut;
   logic autoRunning;

   typedef struct packed {
      logic en;
      logic sw;
      logic run;
   } outVec_t;

   outVec_t    expQ[$];
   outVec_t    want;
   outVec_t    got;
   int         total;
   int         bad;
   logic       loadPair;
   logic [3:0] cntA;
   logic [3:0] cntB;

   counter_ctrl #(.DB_CYCLES(4), .AUTO_SWAP(0)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_run (btn_run),
      .btn_swap(btn_swap),
      .enable  (enable),
      .swap    (swap),
      .running (running)
   );

   counter_ctrl #(.DB_CYCLES(4), .AUTO_SWAP(5)) dutAuto (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_run (autoRun),
      .btn_swap(autoSwapBtn),
      .enable  (autoEnable),
      .swap    (autoSwapOut),
      .running (autoRunning)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stand-in for the downstream counter pair: the two values trade places on a swap cycle.
   always @(posedge clock) begin
      if (loadPair) begin
         cntA <= 4'd3;
         cntB <= 4'd12;
      end else if (enable && swap) begin
         cntA <= cntB;
         cntB <= cntA;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      btn_run     = 1'b0;
      btn_swap    = 1'b0;
      autoRun     = 1'b0;
      autoSwapBtn = 1'b0;
      loadPair    = 1'b0;
      #2;
      for (int k = 0; k < 3; k++) begin
         expQ.push_back(outVec_t'(3'b000));
         expQ.push_back(outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL reset k=%0d got=%b want=%b", k, got, want);
         end
         want = expQ.pop_front();
         got  = {autoEnable, autoSwapOut, autoRunning};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL reset_auto k=%0d got=%b want=%b", k, got, want);
         end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_reset_mid_swap();
      for (int k = 0; k < 7; k++) begin
         btn_swap = (k < 5);
         expQ.push_back((k == 6) ? outVec_t'(3'b110) : outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL mid_swap k=%0d got=%b want=%b", k, got, want);
         end
      end
      btn_swap = 1'b0;
      #2 reset_n = 1'b0;
      expQ.push_back(outVec_t'(3'b000));
      #1;
      want = expQ.pop_front();
      got  = {enable, swap, running};
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL async_reset got=%b want=%b", got, want);
      end
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expQ.push_back(outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL post_reset k=%0d got=%b want=%b", k, got, want);
         end
      end
   endtask

   task automatic test_run_toggle();
      for (int k = 0; k < 20; k++) begin
         btn_run = (k < 10);
         expQ.push_back((k >= 6) ? outVec_t'(3'b101) : outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL run_on k=%0d got=%b want=%b", k, got, want);
         end
      end
      for (int k = 0; k < 20; k++) begin
         btn_run = (k < 10);
         expQ.push_back((k >= 6) ? outVec_t'(3'b000) : outVec_t'(3'b101));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL run_off k=%0d got=%b want=%b", k, got, want);
         end
      end
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 30; k++) begin
         btn_run = (k < 20) && (((k / 2) % 2) == 0);
         expQ.push_back(outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL bounce_low k=%0d got=%b want=%b", k, got, want);
         end
      end
      for (int k = 0; k < 35; k++) begin
         btn_run = (k < 20) ? (((k / 2) % 2) == 0) : 1'b1;
         expQ.push_back((k >= 26) ? outVec_t'(3'b101) : outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL bounce_high k=%0d got=%b want=%b", k, got, want);
         end
      end
      for (int k = 0; k < 30; k++) begin
         btn_run = (k >= 10) && (k < 20);
         expQ.push_back((k >= 16) ? outVec_t'(3'b000) : outVec_t'(3'b101));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL bounce_stop k=%0d got=%b want=%b", k, got, want);
         end
      end
   endtask

   task automatic test_manual_swap();
      loadPair = 1'b1;
      tick();
      loadPair = 1'b0;
      for (int k = 0; k < 12; k++) begin
         btn_swap = (k < 6);
         expQ.push_back((k == 6) ? outVec_t'(3'b110) : outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL manual_swap k=%0d got=%b want=%b", k, got, want);
         end
      end
      total++;
      if (cntA !== 4'd12 || cntB !== 4'd3) begin
         bad++;
         $display("[TB] FAIL pair_swap got=%0d/%0d want=12/3", cntA, cntB);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 20; k++) begin
         btn_run  = (k < 10);
         btn_swap = (k < 10);
         if (k < 6)
            expQ.push_back(outVec_t'(3'b000));
         else if (k == 6)
            expQ.push_back(outVec_t'(3'b111));
         else
            expQ.push_back(outVec_t'(3'b101));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL both_from_stop k=%0d got=%b want=%b", k, got, want);
         end
      end
      for (int k = 0; k < 20; k++) begin
         btn_run  = (k < 10);
         btn_swap = (k < 10);
         if (k < 6)
            expQ.push_back(outVec_t'(3'b101));
         else if (k == 6)
            expQ.push_back(outVec_t'(3'b110));
         else
            expQ.push_back(outVec_t'(3'b000));
         tick();
         want = expQ.pop_front();
         got  = {enable, swap, running};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL both_from_run k=%0d got=%b want=%b", k, got, want);
         end
      end
   endtask

   // Run windows: entered at 6 and 56, stopped mid-period at 33 and 76.
   task automatic test_auto_swap();
      int start;
      for (int k = 0; k < 90; k++) begin
         autoRun = (k < 10) || (k >= 27 && k < 37) || (k >= 50 && k < 60) || (k >= 70 && k < 80);
         if (k >= 6 && k < 33)
            start = 6;
         else if (k >= 56 && k < 76)
            start = 56;
         else
            start = -1;
         if (start < 0)
            expQ.push_back(outVec_t'(3'b000));
         else if (((k - start) % 6) == 5)
            expQ.push_back(outVec_t'(3'b111));
         else
            expQ.push_back(outVec_t'(3'b101));
         tick();
         want = expQ.pop_front();
         got  = {autoEnable, autoSwapOut, autoRunning};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL auto_swap k=%0d got=%b want=%b", k, got, want);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_reset_mid_swap();
      test_run_toggle();
      test_bounce();
      test_manual_swap();
      test_back_to_back();
      test_auto_swap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
